// File: rtl/mpx_limiter.sv
// mpx_limiter: lookahead peak limiter for the stereo composite (MPX) stream.
// A LOOKAHEAD-deep delay line gives the gain state machine time to pull the
// gain down before a peak reaches the multiplier. The output is then limited
// to the signed 16-bit range.
//
// Optional feature macro: MPX_LIMITER_HARDCLIP_EN
//   defined   : the output is clamped to [-threshold, +threshold] and clamp
//               events are counted in clip_count (saturating).
//   undefined : 16-bit saturation only, clip_count tied to 0.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | unity gain, nothing being limited
// ST_ATTACK  | last valid was over threshold, gain just stepped down
// ST_HOLD    | gain frozen while hold_q counts down to terminal 0
// ST_RELEASE | gain climbing by release_step back toward unity

module mpx_limiter #(
    parameter int          LOOKAHEAD = 8,        // power of 2, 2..64
    parameter logic [15:0] GAIN_MIN  = 16'h0800  // gain floor, Q1.15
) (
    input  logic        mclk,
    input  logic        mresetn,
    input  logic [15:0] threshold,
    input  logic [15:0] attack_step,
    input  logic [15:0] release_step,
    input  logic [15:0] mpx_in,
    input  logic        mpx_in_valid,
    output logic [15:0] mpx_out,
    output logic        mpx_out_valid,
    output logic [15:0] gain,
    output logic        limiting,
    output logic [15:0] clip_count
);

    localparam int            HW         = $clog2(LOOKAHEAD + 1);
    localparam logic [HW-1:0] HOLD_INIT  = HW'(LOOKAHEAD);
    localparam logic [15:0]   GAIN_UNITY = 16'h8000;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ATTACK  = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // lookahead delay line
    logic [15:0]        dline [LOOKAHEAD];
    logic [15:0]        d;

    // peak detection
    logic [15:0]        mag;
    logic               over;

    // gain state machine
    logic [1:0]         state_q;
    logic [1:0]         state_nxt;
    logic [HW-1:0]      hold_q;
    logic [HW-1:0]      hold_nxt;
    logic [15:0]        gain_q;
    logic [15:0]        gain_nxt;
    logic               limiting_q;
    logic [16:0]        gain_dec;
    logic [16:0]        gain_inc;
    logic [15:0]        gain_att;
    logic [15:0]        gain_rel;

    // multiply and output pipeline
    logic signed [31:0] prod;
    logic               prod_unused;
    logic signed [16:0] p_q;
    logic               p_vld_q;
    logic signed [17:0] p_ext;
    logic signed [17:0] clamped;
    logic [15:0]        out_val;
    logic [15:0]        out_q;
    logic               out_vld_q;

`ifdef MPX_LIMITER_HARDCLIP_EN
    logic signed [17:0] thr_pos;
    logic signed [17:0] thr_neg;
    logic               clip_evt;
    logic [15:0]        clip_q;
`endif

    // Shift a new sample into the delay line on every input valid
    always_ff @(posedge mclk) begin
        if (!mresetn) begin
            for (int i = 0; i < LOOKAHEAD; i++) begin
                dline[i] <= '0;
            end
        end else if (mpx_in_valid) begin
            dline[0] <= mpx_in;
            for (int i = 1; i < LOOKAHEAD; i++) begin
                dline[i] <= dline[i-1];
            end
        end
    end

    // The oldest entry is the sample presented to the multiplier
    assign d = dline[LOOKAHEAD-1];

    // Magnitude of the incoming sample; -32768 saturates so it fits 15 bits
    always_comb begin
        if (mpx_in == 16'h8000) begin
            mag = 16'h7FFF;
        end else if (mpx_in[15]) begin
            mag = ~mpx_in + 16'd1;
        end else begin
            mag = mpx_in;
        end
    end

    assign over = (mag > threshold);

    // 17-bit gain arithmetic so neither direction can wrap
    assign gain_dec = {1'b0, gain_q} - {1'b0, attack_step};
    assign gain_inc = {1'b0, gain_q} + {1'b0, release_step};

    // Saturate the attack result at the floor and the release result at unity
    always_comb begin
        if (gain_dec[16] || (gain_dec[15:0] < GAIN_MIN)) begin
            gain_att = GAIN_MIN;
        end else begin
            gain_att = gain_dec[15:0];
        end
        if (gain_inc >= {1'b0, GAIN_UNITY}) begin
            gain_rel = GAIN_UNITY;
        end else begin
            gain_rel = gain_inc[15:0];
        end
    end

    // Next-state logic; an over-threshold sample restarts ATTACK from any state
    always_comb begin
        state_nxt = state_q;
        hold_nxt  = hold_q;
        gain_nxt  = gain_q;
        if (over) begin
            gain_nxt  = gain_att;
            hold_nxt  = HOLD_INIT;
            state_nxt = ST_ATTACK;
        end else begin
            case (state_q)
                ST_ATTACK, ST_HOLD: begin
                    hold_nxt  = hold_q - HW'(1);
                    state_nxt = (hold_nxt == '0) ? ST_RELEASE : ST_HOLD;
                end
                ST_RELEASE: begin
                    gain_nxt = gain_rel;
                    if (gain_rel == GAIN_UNITY) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = state_q;
                end
            endcase
        end
    end

    // Gain state registers advance only on input valids
    always_ff @(posedge mclk) begin
        if (!mresetn) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            gain_q     <= GAIN_UNITY;
            limiting_q <= 1'b0;
        end else if (mpx_in_valid) begin
            state_q    <= state_nxt;
            hold_q     <= hold_nxt;
            gain_q     <= gain_nxt;
            limiting_q <= (state_nxt != ST_IDLE);
        end
    end

    // Delayed sample times the pre-update gain; gain never exceeds 2^15 so
    // prod[31:15] is the exact arithmetic shift by 15
    assign prod        = $signed({{16{d[15]}}, d}) * $signed({16'b0, gain_q});
    assign prod_unused = ^prod[14:0];

    // First pipeline stage: capture the scaled sample
    always_ff @(posedge mclk) begin
        if (!mresetn) begin
            p_q     <= '0;
            p_vld_q <= 1'b0;
        end else begin
            p_vld_q <= mpx_in_valid;
            if (mpx_in_valid) begin
                p_q <= prod[31:15];
            end
        end
    end

    // Output limiting: optional clamp to +/-threshold, then 16-bit saturation
    always_comb begin
        p_ext   = {p_q[16], p_q};
        clamped = p_ext;
`ifdef MPX_LIMITER_HARDCLIP_EN
        thr_pos  = $signed({2'b00, threshold});
        thr_neg  = -thr_pos;
        clip_evt = 1'b0;
        if (p_ext > thr_pos) begin
            clamped  = thr_pos;
            clip_evt = 1'b1;
        end else if (p_ext < thr_neg) begin
            clamped  = thr_neg;
            clip_evt = 1'b1;
        end
`endif
        if (clamped > 18'sd32767) begin
            out_val = 16'h7FFF;
        end else if (clamped < -18'sd32768) begin
            out_val = 16'h8000;
        end else begin
            out_val = clamped[15:0];
        end
    end

    // Second pipeline stage: registered output and one-cycle strobe
    always_ff @(posedge mclk) begin
        if (!mresetn) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= p_vld_q;
            if (p_vld_q) begin
                out_q <= out_val;
            end
        end
    end

`ifdef MPX_LIMITER_HARDCLIP_EN
    // Count clamped output samples, sticking at all-ones
    always_ff @(posedge mclk) begin
        if (!mresetn) begin
            clip_q <= '0;
        end else if (p_vld_q && clip_evt && (clip_q != 16'hFFFF)) begin
            clip_q <= clip_q + 16'd1;
        end
    end

    assign clip_count = clip_q;
`else
    assign clip_count = '0;
`endif

    assign mpx_out       = out_q;
    assign mpx_out_valid = out_vld_q;
    assign gain          = gain_q;
    assign limiting      = limiting_q;

endmodule

// File: tb/tb_mpx_limiter.sv
// tb_mpx_limiter: directed scenarios plus randomized traffic for mpx_limiter,
// checked every cycle against a sample-level behavioural model.
// Builds with or without MPX_LIMITER_HARDCLIP_EN; expectations follow the macro.

module tb_mpx_limiter;

    localparam int LA   = 8;
    localparam int GMIN = 'h0800;
`ifdef MPX_LIMITER_HARDCLIP_EN
    localparam bit HC = 1'b1;
`else
    localparam bit HC = 1'b0;
`endif

    typedef enum {M_IDLE, M_ATTACK, M_HOLD, M_RELEASE} mode_t;

    logic        mclk = 1'b0;
    logic        mresetn;
    logic [15:0] thr;
    logic [15:0] atk;
    logic [15:0] rel;
    logic [15:0] mpx_in;
    logic        mpx_in_valid;
    logic [15:0] mpx_out;
    logic        mpx_out_valid;
    logic [15:0] gain;
    logic        limiting;
    logic [15:0] clip_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    // model state: values the DUT registers must hold after the next edge
    int    hist[$];
    int    m_gain;
    int    m_hold;
    int    m_clip;
    int    m_out;
    bit    m_out_vld;
    bit    m_was_reset;
    int    s1_p;
    bit    s1_vld;
    mode_t m_mode;

    mpx_limiter #(.LOOKAHEAD(LA), .GAIN_MIN(16'h0800)) dut (
        .mclk         (mclk),
        .mresetn      (mresetn),
        .threshold    (thr),
        .attack_step  (atk),
        .release_step (rel),
        .mpx_in       (mpx_in),
        .mpx_in_valid (mpx_in_valid),
        .mpx_out      (mpx_out),
        .mpx_out_valid(mpx_out_valid),
        .gain         (gain),
        .limiting     (limiting),
        .clip_count   (clip_count)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int floor_q15(input longint x);
        if (x >= 0) return int'(x / 32768);
        return int'(-((-x + 32767) / 32768));
    endfunction

    function automatic int out_fn(input int p);
        int v;
        v = p;
        if (HC) begin
            if (v > int'(thr)) v = int'(thr);
            else if (v < -int'(thr)) v = -int'(thr);
        end
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Advance the model by one clock using the inputs just driven
    task automatic model_step();
        int d;
        int s;
        int a;
        if (!mresetn) begin
            hist.delete();
            repeat (LA) hist.push_back(0);
            m_gain      = 32768;
            m_hold      = 0;
            m_clip      = 0;
            m_out       = 0;
            m_out_vld   = 1'b0;
            m_was_reset = 1'b1;
            s1_p        = 0;
            s1_vld      = 1'b0;
            m_mode      = M_IDLE;
        end else begin
            m_was_reset = 1'b0;
            m_out_vld   = s1_vld;
            if (s1_vld) begin
                m_out = out_fn(s1_p);
                if (HC && iabs(s1_p) > int'(thr) && m_clip < 65535) m_clip++;
            end
            s1_vld = mpx_in_valid;
            if (mpx_in_valid) begin
                s = int'($signed(mpx_in));
                d = hist.pop_front();
                hist.push_back(s);
                s1_p = floor_q15(longint'(d) * longint'(m_gain));
                a = (s == -32768) ? 32767 : iabs(s);
                if (a > int'(thr)) begin
                    m_gain = m_gain - int'(atk);
                    if (m_gain < GMIN) m_gain = GMIN;
                    m_hold = LA;
                    m_mode = M_ATTACK;
                end else if (m_mode == M_ATTACK || m_mode == M_HOLD) begin
                    m_hold = m_hold - 1;
                    m_mode = (m_hold == 0) ? M_RELEASE : M_HOLD;
                end else if (m_mode == M_RELEASE) begin
                    m_gain = m_gain + int'(rel);
                    if (m_gain >= 32768) begin
                        m_gain = 32768;
                        m_mode = M_IDLE;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input logic rst_n, input logic vld, input int s);
        @(negedge mclk);
        #1;
        mresetn      = rst_n;
        mpx_in_valid = vld;
        mpx_in       = 16'(s);
        model_step();
        armed = 1'b1;
    endtask

    task automatic settle();
        @(posedge mclk);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, i[0], 100 * i);
    endtask

    function automatic int rand_sample(input int t);
        int v;
        case ($urandom_range(0, 3))
            0: v = int'($urandom_range(0, 2000)) - 1000;
            1: v = int'($urandom_range(0, 65535)) - 32768;
            2: begin
                case ($urandom_range(0, 2))
                    0: v = 32767;
                    1: v = -32768;
                    default: v = -32767;
                endcase
            end
            default: begin
                v = t + int'($urandom_range(0, 2)) - 1;
                if (v > 32767) v = 32767;
                if ($urandom_range(0, 1) != 0) v = -v;
            end
        endcase
        return v;
    endfunction

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge mclk) begin
        if (armed) begin
            chk("out_valid", int'(mpx_out_valid), int'(m_out_vld));
            chk("gain", int'(gain), m_gain);
            chk("limiting", int'(limiting), int'(m_mode != M_IDLE));
            chk("clip_count", int'(clip_count), m_clip);
            if (m_out_vld || m_was_reset) chk("mpx_out", int'($signed(mpx_out)), m_out);
        end
    end

    initial begin
        mresetn      = 1'b0;
        mpx_in_valid = 1'b0;
        mpx_in       = '0;
        thr          = 16'h4000;
        atk          = 16'h0800;
        rel          = 16'h0100;

        // reset with valids toggling
        do_reset(4);
        settle();
        chk("rst_gain", int'(gain), 'h8000);
        chk("rst_limiting", int'(limiting), 0);
        chk("rst_out", int'(mpx_out), 0);
        chk("rst_out_valid", int'(mpx_out_valid), 0);
        chk("rst_clip", int'(clip_count), 0);

        // passthrough at unity gain
        for (int j = 1; j <= 10; j++) begin
            cyc(1'b1, 1'b1, 1000);
            settle();
            if (j == 9) chk("pass_out8", int'($signed(mpx_out)), 0);
            if (j == 10) begin
                chk("pass_out9", int'($signed(mpx_out)), 1000);
                chk("pass_out9_valid", int'(mpx_out_valid), 1);
                chk("pass_gain", int'(gain), 'h8000);
                chk("pass_limiting", int'(limiting), 0);
            end
        end

        // single spike
        thr = 16'd16384; atk = 16'h0800; rel = 16'h0100;
        do_reset(2);
        repeat (3) cyc(1'b1, 1'b1, 0);
        cyc(1'b1, 1'b1, 20000);
        settle();
        chk("model_spike_gain", m_gain, 'h7800);
        chk("spike_gain", int'(gain), 'h7800);
        chk("spike_limiting", int'(limiting), 1);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b1, 0);
            settle();
            if (i == 8) begin
                chk("hold_end_gain", int'(gain), 'h7800);
                chk("hold_end_limiting", int'(limiting), 1);
            end
            if (i == 9) begin
                chk("model_spike_out", m_out, HC ? 16384 : 18750);
                chk("spike_out", int'($signed(mpx_out)), HC ? 16384 : 18750);
                chk("spike_clip", int'(clip_count), HC ? 1 : 0);
                chk("release1_gain", int'(gain), 'h7900);
            end
            if (i == 15) chk("release7_gain", int'(gain), 'h7F00);
            if (i == 16) begin
                chk("release_done_gain", int'(gain), 'h8000);
                chk("release_done_limiting", int'(limiting), 0);
            end
        end

        // attack floor
        thr = 16'd16384; atk = 16'h4000;
        do_reset(2);
        cyc(1'b1, 1'b1, 32767); settle();
        chk("floor_gain1", int'(gain), 'h4000);
        cyc(1'b1, 1'b1, 32767); settle();
        chk("model_floor", m_gain, 'h0800);
        chk("floor_gain2", int'(gain), 'h0800);
        cyc(1'b1, 1'b1, 32767); settle();
        chk("floor_gain3", int'(gain), 'h0800);
        chk("floor_limiting", int'(limiting), 1);

        // boundary: -32768 against a full-scale threshold
        thr = 16'h7FFF; atk = 16'h0800;
        do_reset(2);
        for (int j = 1; j <= 10; j++) begin
            cyc(1'b1, 1'b1, -32768);
            settle();
            if (j == 1) begin
                chk("bound_gain", int'(gain), 'h8000);
                chk("bound_limiting", int'(limiting), 0);
            end
            if (j == 10) chk("bound_out", int'($signed(mpx_out)), HC ? -32767 : -32768);
        end

        // reset in the middle of an attack
        thr = 16'd16384; atk = 16'h1000;
        do_reset(2);
        cyc(1'b1, 1'b1, 32767);
        cyc(1'b1, 1'b1, 32767);
        settle();
        chk("mid_pre_gain", int'(gain), 'h6000);
        cyc(1'b0, 1'b1, 32767);
        settle();
        chk("mid_rst_gain", int'(gain), 'h8000);
        chk("mid_rst_limiting", int'(limiting), 0);
        for (int j = 1; j <= 10; j++) begin
            cyc(1'b1, 1'b1, 500);
            settle();
            if (j == 1) chk("mid_discard_valid", int'(mpx_out_valid), 0);
            if (j >= 2 && j <= 9) chk("mid_zero_out", int'($signed(mpx_out)), 0);
            if (j == 10) chk("mid_first_sample", int'($signed(mpx_out)), 500);
        end

        // randomized traffic, configuration changed only while the pipeline is empty
        for (int blk = 0; blk < 12; blk++) begin
            repeat (3) cyc(1'b1, 1'b0, 0);
            settle();
            thr = 16'($urandom_range(16'h0800, 16'h8000));
            atk = 16'($urandom_range(16'h0100, 16'h2000));
            rel = 16'($urandom_range(16'h0040, 16'h0800));
            for (int k = 0; k < 250; k++) begin
                cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 99) < 75),
                    rand_sample(int'(thr)));
            end
        end
        repeat (3) cyc(1'b1, 1'b0, 0);
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mpx_limiter.md
# mpx_limiter

Peak limiter for the stereo composite (MPX) stream, placed directly downstream of the stereo multiplexer and consuming its `mpx_out`/`mpx_valid` sample stream. A sample-based lookahead delay line lets gain reduction begin before a peak reaches the output. An attack/hold/release gain state machine and a final hard clip keep the composite within a programmable threshold before FM modulation.

## Interface
- `LOOKAHEAD`, 8: delay-line depth in samples; power of 2, range 2..64
- `GAIN_MIN`, 16'h0800: gain floor in unsigned Q1.15 (1/16)
- `mclk`  in  1  sample-domain clock
- `mresetn`  in  1  reset; synchronous and active-low
- `threshold`  in  16  unsigned limit level, quasi-static
- `attack_step`  in  16  gain decrement per over-threshold sample, Q1.15
- `release_step`  in  16  gain increment per release sample, Q1.15
- `mpx_in`  in  16  signed composite sample
- `mpx_in_valid`  in  1  sample strobe; may be high every cycle
- `mpx_out`  out  16  signed limited sample
- `mpx_out_valid`  out  1  output strobe
- `gain`  out  16  current gain, unsigned Q1.15, unity = 16'h8000
- `limiting`  out  1  high when state is not IDLE
- `clip_count`  out  16  hard-clip events, saturating

## Operation
- All logic advances only on cycles where `mpx_in_valid` is high, except the output pipeline.
- Delay line: LOOKAHEAD entries, reset to 0. Each valid shifts in `mpx_in` and presents the sample from LOOKAHEAD valids earlier (`d`).
- Magnitude: `a = |mpx_in|`. -32768 saturates to 32767. The sample is over threshold when `a > threshold` (strictly greater).
- States: IDLE, ATTACK, HOLD, RELEASE. The following rules are evaluated per valid:
  - Over threshold (any state): `gain <= max(gain - attack_step, GAIN_MIN)`, `hold_cnt <= LOOKAHEAD`, next state ATTACK.
  - Not over, in ATTACK or HOLD: `hold_cnt -= 1`. If the new value is 0, next state RELEASE; otherwise HOLD.
  - Not over, in RELEASE: `gain <= min(gain + release_step, 16'h8000)`. If the result is 16'h8000, next state IDLE.
  - Not over, in IDLE: no change.
- Gain subtraction and addition are done at 17 bits before saturation; there is no wrap-around.
- Product: `p = (d * gain) >>> 15`, a 32-bit signed arithmetic shift that truncates toward -inf. The product uses the gain value *before* the update made on the same valid.
- With unity gain, `p == d` exactly, including -32768.
- `limiting = (state != IDLE)`, registered.

## Timing
- The valid on cycle k captures `p` at edge k+1. `mpx_out` and `mpx_out_valid` register at edge k+2, so latency is 2 mclk from `mpx_in_valid` to `mpx_out_valid`.
- `mpx_out_valid` is a one-cycle pulse per input valid. Back-to-back valids give back-to-back outputs.
- `gain`, state, and `hold_cnt` update at edge k+1.
- Values after reset, one edge with `mresetn` low: `mpx_out`=0, `mpx_out_valid`=0, `gain`=16'h8000, `limiting`=0, `clip_count`=0, state IDLE, `hold_cnt`=0, delay line and pipeline cleared.
- Reset mid-operation discards any in-flight sample. No `mpx_out_valid` is produced for a valid that lands on a reset cycle.
- A change to `threshold`, `attack_step`, or `release_step` takes effect on the next valid. These inputs must not change between a valid and its output.

## Configuration
- `MPX_LIMITER_HARDCLIP_EN` defined:
  - The output stage clamps `p` to `[-threshold, +threshold]`.
  - Each valid output whose `|p| > threshold` increments `clip_count`, saturating at 16'hFFFF.
- Not defined:
  - `mpx_out` is `p` saturated to the 16-bit signed range only.
  - `clip_count` is tied to 0.
  - Latency is unchanged.

## Test plan
- Reset: hold `mresetn` low with valids toggling. Required: `mpx_out`=0, `mpx_out_valid`=0, `gain`=16'h8000, `limiting`=0, `clip_count`=0.
- Passthrough: `threshold`=16'h4000, `mpx_in`=1000 on every cycle. Required: the first 8 outputs are 0, then 1000, 2 cycles after each valid. `gain` stays 16'h8000 and `limiting` stays 0.
- Single spike with HARDCLIP_EN:
  - Setup: `threshold`=16384, `attack_step`=16'h0800, `release_step`=16'h0100, one sample of 20000 among zeros.
  - Gain: 16'h7800, holds for 8 valids, then RELEASE climbs to 16'h8000 over 8 valids and returns to IDLE.
  - Output: the spike emerges as 18750 clamped to 16384, and `clip_count` becomes 1.
- Attack floor: `attack_step`=16'h4000, continuous 32767. Required: `gain` goes 16'h4000, then 16'h0800, and stays at 16'h0800. State remains ATTACK.
- Boundary: `threshold`=16'h7FFF, `mpx_in`=-32768. Required: not over threshold, `gain` unchanged, output -32768.
- Reset mid-operation: pull `mresetn` low for one cycle while in ATTACK with `gain`=16'h6000. Required: `gain`=16'h8000, state IDLE, and the next 8 outputs are 0.
